// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter multiplexing NUM_CH byte-wide clients onto one SDRAM
// controller port, with download-exclusive mode and a ready-timeout watchdog.
module mem_port_arbiter #(
    parameter int NUM_CH = 4,
    parameter int AW     = 23,
    parameter int DW     = 8,
    parameter int DL_CH  = 0,
    parameter int TMO    = 15
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         req_rd,
    input  logic [NUM_CH-1:0]         req_wr,
    input  logic [NUM_CH*AW-1:0]      req_addr,
    input  logic [NUM_CH*DW-1:0]      req_din,
    output logic [NUM_CH-1:0]         req_ack,
    output logic [DW-1:0]             req_dout,
    input  logic                      dl_active,
    output logic [AW-1:0]             ram_addr,
    output logic [DW-1:0]             ram_din,
    output logic                      ram_we,
    output logic                      ram_rd,
    input  logic                      ram_ready,
    input  logic [DW-1:0]             ram_dout,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant,
    output logic                      tmo_err
);

    localparam int GW = $clog2(NUM_CH);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [NUM_CH-1:0]   w_elig;
    logic                w_found;
    logic [GW-1:0]       w_pick;
    logic [GW-1:0]       w_idx;
    logic                w_tmo_hit;
    logic                w_capture;
    logic [NUM_CH-1:0]   w_onehot;

    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_last;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_din;
    logic                r_is_wr;
    logic                r_we;
    logic                r_rd;
    logic [CW-1:0]       r_cnt;
    logic [NUM_CH-1:0]   r_ack;
    logic [DW-1:0]       r_dout;
    logic                r_tmo;
    logic                r_busy;

    // During a download only the download channel may compete.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_elig
        assign w_elig[g] = (req_rd[g] | req_wr[g]) & (~dl_active | (g == DL_CH));
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = GW'((int'(r_last) + k) % NUM_CH);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state decode plus the capture/timeout qualifiers.
    always_comb begin
        w_next    = r_state;
        w_tmo_hit = 1'b0;
        w_capture = 1'b0;
        w_onehot  = '0;
        w_onehot[r_grant] = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_found && ram_ready) w_next = ST_ISSUE;
                else                      w_next = ST_IDLE;
            end
            ST_ISSUE: w_next = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (!ram_ready) begin
                    w_next = ST_WAIT_HI;
                end else if (r_cnt == CW'(TMO - 1)) begin
                    w_next    = ST_ACK;
                    w_tmo_hit = 1'b1;
                    w_capture = ~r_is_wr;
                end else begin
                    w_next = ST_WAIT_LO;
                end
            end
            ST_WAIT_HI: begin
                if (ram_ready) begin
                    w_next    = ST_ACK;
                    w_capture = ~r_is_wr;
                end else begin
                    w_next = ST_WAIT_HI;
                end
            end
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Grant latch, strobes, watchdog counter and sticky status.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_grant <= '0;
            r_last  <= GW'(NUM_CH - 1);
            r_addr  <= '0;
            r_din   <= '0;
            r_is_wr <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= 1'b0;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_dout  <= '0;
            r_tmo   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_rd   <= 1'b0;
            r_busy <= (w_next != ST_IDLE);
            r_ack  <= (w_next == ST_ACK) ? w_onehot : '0;
            if (r_state == ST_IDLE && w_next == ST_ISSUE) begin
                r_grant <= w_pick;
                r_last  <= w_pick;
                r_addr  <= req_addr[w_pick*AW +: AW];
                r_din   <= req_din[w_pick*DW +: DW];
                r_is_wr <= req_wr[w_pick];
                r_we    <= req_wr[w_pick];
                r_rd    <= ~req_wr[w_pick];
            end
            if (r_state == ST_ISSUE) r_cnt <= '0;
            else if (r_state == ST_WAIT_LO && ram_ready) r_cnt <= r_cnt + CW'(1);
            if (w_capture) r_dout <= ram_dout;
            if (w_tmo_hit) r_tmo <= 1'b1;
        end
    end

    assign req_ack  = r_ack;
    assign req_dout = r_dout;
    assign ram_addr = r_addr;
    assign ram_din  = r_din;
    assign ram_we   = r_we;
    assign ram_rd   = r_rd;
    assign busy     = r_busy;
    assign grant    = r_grant;
    assign tmo_err  = r_tmo;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter; a transaction-timeline
// model predicts every output each cycle from grant decisions and ready plans.
module tb_mem_port_arbiter;

    localparam int N = 4, AW = 23, DW = 8, DL = 0, TMO = 15, GW = 2;

    logic            clk_sys = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    req_rd, req_wr, req_ack;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_din;
    logic [DW-1:0]   req_dout, ram_din, ram_dout;
    logic            dl_active, ram_we, ram_rd, ram_ready, busy, tmo_err;
    logic [AW-1:0]   ram_addr;
    logic [GW-1:0]   grant;

    mem_port_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .DL_CH(DL), .TMO(TMO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_din(req_din), .req_ack(req_ack), .req_dout(req_dout),
        .dl_active(dl_active), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_rd(ram_rd), .ram_ready(ram_ready), .ram_dout(ram_dout), .busy(busy),
        .grant(grant), .tmo_err(tmo_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_err = 0, cyc = 0;
    // model of the access currently or last in flight
    int m_issue, m_ack, m_lo_s, m_lo_e, m_last;
    logic [GW-1:0] m_grant;
    bit            m_wr, m_tmo, m_acc_tmo;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_dout;
    // clients
    bit            c_pend[N], c_rd[N], c_wr[N], c_auto[N];
    logic [AW-1:0] c_addr[N];
    logic [DW-1:0] c_din[N];
    int            c_rate;
    // stimulus controls
    int fix_lo, fix_hi, fix_dout, tmo_pct, ready_idle_pct;
    bit force_tmo, dl_rand, dl_v;
    // observations
    int n_we, n_rd, n_ack, last_ack_cyc, dec_cyc;
    int gq[$];
    logic [AW-1:0] rec_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clr_rec();
        n_we = 0; n_rd = 0; n_ack = 0; last_ack_cyc = -1; dec_cyc = -1;
        gq.delete();
    endtask

    task automatic new_req(input int ch, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_pend[ch] = 1'b1; c_rd[ch] = rd; c_wr[ch] = wr; c_addr[ch] = a; c_din[ch] = d;
    endtask

    task automatic rand_req(input int ch);
        int op;
        op = $urandom_range(0, 2);
        new_req(ch, op != 1, op != 0, AW'($urandom), DW'($urandom));
    endtask

    task automatic drive_clients();
        for (int i = 0; i < N; i++) begin
            req_rd[i] = c_pend[i] & c_rd[i];
            req_wr[i] = c_pend[i] & c_wr[i];
            req_addr[i*AW +: AW] = c_addr[i];
            req_din[i*DW +: DW]  = c_din[i];
        end
        dl_active = dl_v;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_rd", ram_rd, 1'b0);
        chk("rst_req_ack", req_ack, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, '0);
        chk("rst_ram_addr", ram_addr, '0);
        chk("rst_req_dout", req_dout, '0);
        chk("rst_tmo_err", tmo_err, 1'b0);
        m_issue = -100; m_ack = -100; m_lo_s = -100; m_lo_e = -100; m_last = N - 1;
        m_grant = '0; m_wr = 0; m_tmo = 0; m_acc_tmo = 0;
        m_addr = '0; m_din = '0; m_dout = '0;
        for (int i = 0; i < N; i++) begin
            c_pend[i] = 0; c_rd[i] = 0; c_wr[i] = 0; c_auto[i] = 0; c_addr[i] = '0; c_din[i] = '0;
        end
        c_rate = 0; fix_lo = -1; fix_hi = -1; fix_dout = -1; tmo_pct = 0;
        ready_idle_pct = 100; force_tmo = 0; dl_rand = 0; dl_v = 0;
        drive_clients();
        ram_ready = 1'b1; ram_dout = '0;
        clr_rec();
        @(posedge clk_sys); @(posedge clk_sys); #3;
        reset_n = 1'b1;
    endtask

    // One clock cycle: check outputs, drive inputs, then advance the model.
    task automatic step();
        logic [N-1:0] ea;
        int  ci, lo, hi;
        bit  found, inflight;
        @(posedge clk_sys); #1;
        cyc++;
        ea = '0;
        if (cyc == m_ack) ea[m_grant] = 1'b1;
        chk("busy", busy, (cyc >= m_issue && cyc <= m_ack));
        chk("ram_we", ram_we, (cyc == m_issue && m_wr));
        chk("ram_rd", ram_rd, (cyc == m_issue && !m_wr));
        chk("req_ack", req_ack, ea);
        chk("grant", grant, m_grant);
        chk("ram_addr", ram_addr, m_addr);
        chk("ram_din", ram_din, m_din);
        chk("req_dout", req_dout, m_dout);
        chk("tmo_err", tmo_err, m_tmo);
        if (ram_we || ram_rd) begin gq.push_back(int'(grant)); rec_addr = ram_addr; end
        if (ram_we) n_we++;
        if (ram_rd) n_rd++;
        if (req_ack != '0) begin n_ack++; last_ack_cyc = cyc; end

        if (cyc == m_ack + 1) c_pend[m_grant] = 1'b0;
        for (int i = 0; i < N; i++)
            if (!c_pend[i] && c_auto[i] && !(cyc == m_ack + 1 && i == int'(m_grant))
                && $urandom_range(0, 99) < c_rate)
                rand_req(i);
        if (dl_rand && $urandom_range(0, 39) == 0) dl_v = !dl_v;
        drive_clients();
        inflight  = (cyc >= m_issue) && (cyc <= m_ack);
        ram_ready = inflight ? !(cyc >= m_lo_s && cyc <= m_lo_e)
                             : ($urandom_range(0, 99) < ready_idle_pct);
        ram_dout  = (fix_dout >= 0) ? DW'(fix_dout) : DW'($urandom);

        if (!inflight && ram_ready) begin
            found = 0; ci = 0;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (!found && c_pend[j] && (!dl_v || j == DL)) begin found = 1; ci = j; end
            end
            if (found) begin
                dec_cyc = cyc; m_issue = cyc + 1; m_grant = GW'(ci); m_last = ci;
                m_wr = c_wr[ci]; m_addr = c_addr[ci]; m_din = c_din[ci];
                m_acc_tmo = force_tmo || ($urandom_range(0, 99) < tmo_pct);
                if (m_acc_tmo) begin
                    m_lo_s = -100; m_lo_e = -100; m_ack = cyc + 2 + TMO;
                end else begin
                    lo = (fix_lo >= 0) ? fix_lo : $urandom_range(0, 3);
                    hi = (fix_hi >= 0) ? fix_hi : $urandom_range(1, 3);
                    m_lo_s = cyc + 2 + lo; m_lo_e = m_lo_s + hi - 1; m_ack = m_lo_e + 2;
                end
            end
        end
        if (cyc + 1 == m_ack) begin
            if (!m_wr) m_dout = ram_dout;
            if (m_acc_tmo) m_tmo = 1'b1;
        end
    endtask

    task automatic run_acks(input int target, input int cap, input string name);
        int k;
        k = 0;
        while (n_ack < target && k < cap) begin step(); k++; end
        chk(name, (n_ack >= target), 1'b1);
    endtask

    initial begin
        #(1ms);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_rr[6] = '{0, 2, 3, 0, 2, 3};
        int exp_dl[4] = '{0, 0, 0, 1};
        int k;
        #1;
        do_reset();

        // single read on ch1
        fix_lo = 0; fix_hi = 1; fix_dout = 8'h5A;
        new_req(1, 1'b1, 1'b0, 23'h000123, 8'h00);
        run_acks(1, 30, "single_read_ack");
        chk("single_read_latency", last_ack_cyc - dec_cyc, 4);
        chk("single_read_dout", req_dout, 8'h5A);
        chk("single_read_addr", rec_addr, 23'h000123);
        chk("single_read_strobes", {n_rd[7:0], n_we[7:0]}, 16'h0100);

        // round robin among ch0, ch2, ch3
        do_reset();
        c_rate = 100;
        for (int i = 0; i < N; i++) if (i != 1) begin c_auto[i] = 1; rand_req(i); end
        run_acks(6, 200, "rr_acks");
        chk("rr_count", (gq.size() >= 6), 1'b1);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("rr_order", gq[i], exp_rr[i]);

        // download mode
        do_reset();
        dl_v = 1; c_rate = 100; c_auto[0] = 1; c_auto[1] = 1;
        rand_req(0); rand_req(1);
        run_acks(3, 100, "dl_acks");
        dl_v = 0;
        run_acks(4, 40, "dl_release_ack");
        chk("dl_count", (gq.size() >= 4), 1'b1);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("dl_order", gq[i], exp_dl[i]);

        // rd+wr on the same channel
        do_reset();
        fix_dout = 8'h3C;
        new_req(1, 1'b1, 1'b0, 23'h00_0042, 8'h00);
        run_acks(1, 30, "pre_read_ack");
        fix_dout = -1;
        for (int i = 0; i < 2; i++) step();
        clr_rec();
        new_req(2, 1'b1, 1'b1, 23'h12_3456, 8'hA5);
        run_acks(1, 30, "rdwr_ack");
        for (int i = 0; i < 5; i++) step();
        chk("rdwr_single_ack", n_ack, 1);
        chk("rdwr_we", n_we, 1);
        chk("rdwr_rd", n_rd, 0);
        chk("rdwr_dout_kept", req_dout, 8'h3C);
        chk("rdwr_din", ram_din, 8'hA5);

        // ready never drops
        do_reset();
        force_tmo = 1;
        new_req(0, 1'b1, 1'b0, 23'h00_0777, 8'h00);
        run_acks(1, 40, "tmo_ack");
        chk("tmo_latency", last_ack_cyc - dec_cyc, 17);
        chk("tmo_err_set", tmo_err, 1'b1);
        force_tmo = 0;
        new_req(1, 1'b1, 1'b0, 23'h00_0778, 8'h00);
        run_acks(2, 40, "tmo_next_ack");
        chk("tmo_err_sticky", tmo_err, 1'b1);

        // reset during WAIT_HI, then ch0 first
        do_reset();
        fix_lo = 0; fix_hi = 3;
        new_req(1, 1'b1, 1'b0, 23'h00_0999, 8'h00);
        k = 0;
        while (!(m_issue > 0 && cyc == m_issue + 2) && k < 20) begin step(); k++; end
        chk("mid_busy", busy, 1'b1);
        do_reset();
        new_req(0, 1'b1, 1'b0, 23'h00_0010, 8'h00);
        new_req(1, 1'b0, 1'b1, 23'h00_0011, 8'h11);
        run_acks(1, 20, "post_rst_ack");
        chk("post_rst_count", (gq.size() >= 1), 1'b1);
        if (gq.size() >= 1) chk("post_rst_first", gq[0], 0);

        // random traffic
        do_reset();
        c_rate = 20; tmo_pct = 5; dl_rand = 1; ready_idle_pct = 80;
        for (int i = 0; i < N; i++) c_auto[i] = 1;
        for (int i = 0; i < 4000; i++) step();
        chk("rand_progress", (n_ack > 50), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel byte-wide arbiter between memory clients and the single SDRAM controller port (addr/din/dout/we/rd/ready).
- Replaces the fixed two-way mux between the ioctl download and the core's SRAM bus.
- Adds round-robin fairness, download-exclusive mode, per-channel acknowledge and a ready-timeout watchdog.

Parameters:
- NUM_CH, 4, number of client channels (2..8).
- AW, 23, address width.
- DW, 8, data width.
- DL_CH, 0, channel reserved for ioctl download; it is the only eligible channel while dl_active=1.
- TMO, 15, cycles to wait in WAIT_LO for ram_ready to fall before treating the access as complete.

Ports:
- clk_sys  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- req_rd  in  NUM_CH  per-channel read request, level, held until ack.
- req_wr  in  NUM_CH  per-channel write request, level, held until ack.
- req_addr  in  NUM_CH*AW  flattened addresses; channel i at [i*AW +: AW].
- req_din  in  NUM_CH*DW  flattened write data.
- req_ack  out  NUM_CH  one-cycle completion pulse to the granted channel.
- req_dout  out  DW  last read data, shared by all channels.
- dl_active  in  1  download in progress; masks every channel except DL_CH.
- ram_addr  out  AW  address to the SDRAM controller.
- ram_din  out  DW  write data to the SDRAM controller.
- ram_we  out  1  write strobe.
- ram_rd  out  1  read strobe.
- ram_ready  in  1  controller idle/done; low while busy.
- ram_dout  in  DW  controller read data.
- busy  out  1  high in any state other than IDLE.
- grant  out  $clog2(NUM_CH)  channel currently or last granted.
- tmo_err  out  1  sticky; set when any access exits WAIT_LO by timeout.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All outputs 0, state IDLE, tmo counter 0.
  - Last-grant pointer = NUM_CH-1, so channel 0 has first priority.
  - Asserting reset mid-access drops ram_we/ram_rd immediately; the access is abandoned with no ack.
- Eligibility: channel i is eligible when req_rd[i]|req_wr[i] and (dl_active=0 or i==DL_CH). Ineligible requests wait and are never acked or dropped.
- Priority: round-robin. Search starts at (last_grant+1) mod NUM_CH and wraps. The pointer updates only on grant.
- If req_wr and req_rd are both high on a channel, the write wins; it is a single access with one ack.
- IDLE:
  - If any channel is eligible and ram_ready=1, latch grant, addr, din and operation, then go to ISSUE.
  - With ram_ready=0, stay in IDLE.
- ISSUE (1 cycle): exactly one of ram_we or ram_rd is high. ram_addr and ram_din are registered and stay stable until IDLE. Next state WAIT_LO; tmo counter is cleared.
- WAIT_LO:
  - ram_ready=0 goes to WAIT_HI.
  - Otherwise the counter increments. When it reaches TMO: set tmo_err, capture ram_dout (reads), go to ACK.
- WAIT_HI: on ram_ready=1, capture ram_dout into req_dout (reads only; writes leave req_dout unchanged), then go to ACK.
- ACK (1 cycle): req_ack[grant]=1, then IDLE. No grant is possible in the ACK cycle.
- Client contract: the client drops its request in the cycle after it sees ack. A request still high in the following IDLE is a new access.
- Timing: minimum request-to-ack latency is 4 cycles (request sampled in IDLE at T; ISSUE T+1; ready falls T+2, rises T+3; ack T+4).
- dl_active toggling mid-access does not abort the access; the mask applies at the next IDLE decision.
- req_dout holds its value across writes and resets only on reset_n.
- tmo_err is cleared only by reset_n.

Test Plan:
- Single read: ch1 req_rd at addr 0x000123; model asserts ready low 1 cycle later then high with 0x5A -> one ram_rd pulse, ram_addr=0x000123, req_ack[1] at T+4, req_dout=0x5A.
- Round-robin: ch0, ch2 and ch3 hold requests continuously, each dropping and re-raising after ack -> grant order 0,2,3,0,2,3; no channel is starved.
- Download mode: dl_active=1, ch0 (DL_CH) and ch1 both request -> only ch0 is served for 3 consecutive accesses. Drop dl_active -> ch1 is served next.
- rd+wr together: ch2 req_rd=req_wr=1, din 0xA5 -> ram_we=1, ram_rd=0, a single ack, req_dout unchanged.
- Timeout: model never drops ram_ready -> ack at T+2+TMO, i.e. cycle 17 with TMO=15; tmo_err=1 and stays 1.
- Reset mid-access: reset_n low during WAIT_HI -> ram_we/ram_rd/req_ack/busy are 0 the same instant. After release, a ch0 request is granted first.
